// File: rtl/fourth_root_seq_pkg.sv
// Shared types and constants for the sequential fourth-root unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fourth_root_seq_pkg;

  // Controller states: waiting for operand, extracting bits, holding result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default root width; the operand is four times as wide
  localparam int OUT_W_DEFAULT = 8;

  // Operand/remainder width for a given root width (r^4 needs 4x the bits)
  function automatic int in_width(input int out_w);
    return 4 * out_w;
  endfunction

endpackage

// File: rtl/fourth_root_seq_pow4_unit.sv
// Combinational fourth power: square, then square the square.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
module pow4_unit #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a,
  output logic [4*W-1:0] p
);

  logic [2*W-1:0] sq;

  // Operands are zero-extended first so each product is formed at full width
  always_comb begin
    sq = {{W{1'b0}}, a} * {{W{1'b0}}, a};
    p  = {{(2*W){1'b0}}, sq} * {{(2*W){1'b0}}, sq};
  end

endmodule

// File: rtl/fourth_root_seq.sv
// Bit-serial integer fourth root: root = floor(x^(1/4)), rem = x - root^4, exact flag.
// Latency: result valid OUT_W+1 cycles after acceptance; one op per OUT_W+2 cycles.
// Backpressure: valid/ready both sides; result held in DONE until out_ready, no overlap.
module fourth_root_seq
  import fourth_root_seq_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEFAULT,
  parameter int IN_W  = in_width(OUT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] root,
  output logic [IN_W-1:0]  rem,
  output logic             exact
);

  localparam int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(OUT_W - 1);

  state_t           state;
  state_t           state_nxt;

  logic [IN_W-1:0]  x_q;
  logic [OUT_W-1:0] acc_root;
  logic [IN_W-1:0]  acc_pow;
  logic [IDX_W-1:0] bit_idx;

  logic [OUT_W-1:0] trial_bit;
  logic [OUT_W-1:0] cand;
  logic [IN_W-1:0]  p;
  logic             take;
  logic [OUT_W-1:0] root_nxt;
  logic [IN_W-1:0]  pow_nxt;

  logic             last_bit;

  assign last_bit = (bit_idx == '0);

  // Trial candidate: current partial root with the bit under test set
  always_comb begin
    trial_bit          = '0;
    trial_bit[bit_idx] = 1'b1;
    cand               = acc_root | trial_bit;
  end

  pow4_unit #(
    .W (OUT_W)
  ) u_pow4 (
    .a (cand),
    .p (p)
  );

  // Keep the candidate bit only if its fourth power does not exceed the operand
  always_comb begin
    take     = (p <= x_q);
    root_nxt = take ? cand : acc_root;
    pow_nxt  = take ? p    : acc_pow;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = ITER;
      ITER:    if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, per-bit accumulation, result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      acc_root <= '0;
      acc_pow  <= '0;
      bit_idx  <= '0;
      root     <= '0;
      rem      <= '0;
      exact    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q      <= x;
            acc_root <= '0;
            acc_pow  <= '0;
            bit_idx  <= IDX_TOP;
          end
        end
        ITER: begin
          acc_root <= root_nxt;
          acc_pow  <= pow_nxt;
          if (last_bit) begin
            // pow_nxt <= x_q always holds, so the subtraction cannot wrap
            root  <= root_nxt;
            rem   <= x_q - pow_nxt;
            exact <= (x_q == pow_nxt);
          end else begin
            bit_idx <= bit_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fourth_root_seq.sv
// Directed and round-trip bench for the sequential fourth-root unit.
// Latency: checks result arrives OUT_W edges after acceptance.
// Backpressure: exercises held results, aborted ops and back-to-back streaming.
module tb_fourth_root_seq;

  localparam int OUT_W = 8;
  localparam int IN_W  = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  x;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] root;
  logic [IN_W-1:0]  rem;
  logic             exact;

  int tests;
  int fails;
  int cyc;

  typedef struct {
    logic [31:0] xv;
    logic [7:0]  r;
    logic [31:0] rm;
    logic        ex;
  } vec_t;

  vec_t vecs[13];

  fourth_root_seq #(
    .OUT_W (OUT_W),
    .IN_W  (IN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root),
    .rem       (rem),
    .exact     (exact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Offer one operand, wait for the result, consume it. Called at posedge+#1.
  task automatic do_op(input logic [31:0] xv, input bit keep_rdy,
                       output logic [7:0] r, output logic [31:0] rm,
                       output logic ex, output int lat, output int ocyc);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    x        = xv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x        = 32'hDEADBEEF;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    r    = root;
    rm   = rem;
    ex   = exact;
    ocyc = cyc;
    out_ready = 1'b1;
    @(posedge clk); #1;
    if (!keep_rdy) out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  r;
    logic [31:0] rm;
    logic        ex;
    int          lat;
    int          ocyc;
    int          prev_ocyc;
    int          seen;
    logic [31:0] a4;
    int          a;

    tests = 0;
    fails = 0;

    vecs[0]  = '{32'd81,         8'd3,   32'd0,        1'b1};
    vecs[1]  = '{32'd65536,      8'd16,  32'd0,        1'b1};
    vecs[2]  = '{32'd4228250625, 8'd255, 32'd0,        1'b1};
    vecs[3]  = '{32'd80,         8'd2,   32'd64,       1'b0};
    vecs[4]  = '{32'hFFFFFFFF,   8'd255, 32'd66716670, 1'b0};
    vecs[5]  = '{32'd1,          8'd1,   32'd0,        1'b1};
    vecs[6]  = '{32'd0,          8'd0,   32'd0,        1'b1};
    vecs[7]  = '{32'd15,         8'd1,   32'd14,       1'b0};
    vecs[8]  = '{32'd256,        8'd4,   32'd0,        1'b1};
    vecs[9]  = '{32'd255,        8'd3,   32'd174,      1'b0};
    vecs[10] = '{32'd100000000,  8'd100, 32'd0,        1'b1};
    vecs[11] = '{32'd99999999,   8'd99,  32'd3940398,  1'b0};
    vecs[12] = '{32'd2,          8'd1,   32'd1,        1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_root",      {24'd0, root},      32'd0);
    chk("rst_rem",       rem,                32'd0);
    chk("rst_exact",     {31'd0, exact},     32'd0);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].xv, 1'b0, r, rm, ex, lat, ocyc);
      chk($sformatf("vec%0d_latency", i), lat, OUT_W);
      chk($sformatf("vec%0d_root", i), {24'd0, r}, {24'd0, vecs[i].r});
      chk($sformatf("vec%0d_rem", i), rm, vecs[i].rm);
      chk($sformatf("vec%0d_exact", i), {31'd0, ex}, {31'd0, vecs[i].ex});
      chk($sformatf("vec%0d_release", i), {30'd0, out_valid, in_ready}, 32'd1);
    end

    // Backpressure: hold result 20 cycles while a new operand is offered
    in_valid = 1'b1;
    x        = 32'd81;
    @(posedge clk); #1;
    x = 32'd16;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_latency", lat, OUT_W);
    for (int c = 0; c < 20; c++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
      chk("bp_root",      {24'd0, root},      32'd3);
      chk("bp_rem",       rem,                32'd0);
      chk("bp_exact",     {31'd0, exact},     32'd1);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_root_kept",         {24'd0, root},      32'd3);

    // Reset during the 4th ITER cycle aborts without a result
    in_valid = 1'b1;
    x        = 32'd4228250625;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_busy_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
    chk("abort_root",      {24'd0, root},      32'd0);
    chk("abort_rem",       rem,                32'd0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("abort_no_result", seen, 0);
    do_op(32'd625, 1'b0, r, rm, ex, lat, ocyc);
    chk("after_abort_root",  {24'd0, r},  32'd5);
    chk("after_abort_rem",   rm,          32'd0);
    chk("after_abort_exact", {31'd0, ex}, 32'd1);

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    prev_ocyc = 0;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] sx;
      logic [7:0]  sr;
      logic [31:0] srm;
      logic        sex;
      case (k)
        0:       begin sx = 32'd16;   sr = 8'd2; srm = 32'd0; sex = 1'b1; end
        1:       begin sx = 32'd17;   sr = 8'd2; srm = 32'd1; sex = 1'b0; end
        default: begin sx = 32'd1296; sr = 8'd6; srm = 32'd0; sex = 1'b1; end
      endcase
      do_op(sx, 1'b1, r, rm, ex, lat, ocyc);
      chk($sformatf("b2b%0d_root", k), {24'd0, r}, {24'd0, sr});
      chk($sformatf("b2b%0d_rem", k), rm, srm);
      chk($sformatf("b2b%0d_exact", k), {31'd0, ex}, {31'd0, sex});
      if (k > 0) chk($sformatf("b2b%0d_spacing", k), ocyc - prev_ocyc, 10);
      prev_ocyc = ocyc;
    end
    out_ready = 1'b0;

    // Round trip against the fourth-power relation
    for (int i = 0; i < 10; i++) begin
      a  = (i == 0) ? 255 : ((i == 1) ? 0 : int'($urandom_range(0, 255)));
      a4 = 32'(a) * 32'(a) * 32'(a) * 32'(a);
      do_op(a4, 1'b0, r, rm, ex, lat, ocyc);
      chk($sformatf("rt_pow_root_a%0d", a), {24'd0, r}, 32'(a));
      chk($sformatf("rt_pow_exact_a%0d", a), {31'd0, ex}, 32'd1);
      a  = int'($urandom_range(1, 254));
      a4 = 32'(a) * 32'(a) * 32'(a) * 32'(a) + 32'd1;
      do_op(a4, 1'b0, r, rm, ex, lat, ocyc);
      chk($sformatf("rt_plus1_root_a%0d", a), {24'd0, r}, 32'(a));
      chk($sformatf("rt_plus1_rem_a%0d", a), rm, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
